// File: rtl/keypad_scan_pkg.sv
// Shared constants, state encoding and row-decode helper for the keypad scanner.
package keypad_scan_pkg;

  // Column drive at reset: column 0 driven low, the rest released.
  localparam logic [3:0] KP_COL_INIT = 4'b1110;
  // Row pattern with no key pulling any row low.
  localparam logic [3:0] KP_ROW_IDLE = 4'hF;

  typedef enum logic [1:0] {
    KP_ST_SCAN = 2'd0,
    KP_ST_DEB  = 2'd1,
    KP_ST_HELD = 2'd2
  } kp_state_e;

  // Result of decoding a synchronized row pattern.
  typedef struct packed {
    logic       hit;  // exactly one row is low
    logic [1:0] idx;  // index of that row
  } kp_row_hit_t;

  // Only a single low row counts as a key; zero or several low rows are ignored.
  function automatic kp_row_hit_t kp_decode_row(input logic [3:0] row_s);
    kp_row_hit_t res;
    res.hit = 1'b1;
    res.idx = 2'd0;
    case (row_s)
      4'b1110: res.idx = 2'd0;
      4'b1101: res.idx = 2'd1;
      4'b1011: res.idx = 2'd2;
      4'b0111: res.idx = 2'd3;
      default: res.hit = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad pins plus the pop/read port toward the GPIO peripheral.
interface keypad_scan_if;
  logic [3:0] row;
  logic [3:0] col;
  logic       rd;
  logic [3:0] key_val;
  logic       key_valid;
  logic       overflow;

  // Peripheral / keypad side.
  modport master (
    output row,
    output rd,
    input  col,
    input  key_val,
    input  key_valid,
    input  overflow
  );

  // Scanner side.
  modport slave (
    input  row,
    input  rd,
    output col,
    output key_val,
    output key_valid,
    output overflow
  );
endinterface

// File: rtl/keypad_scan_fifo.sv
// Small key-code queue; pointers carry an extra wrap bit to tell full from empty.
module keypad_scan_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // A pop frees a slot in the same cycle, so a push while full is still taken.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  assign o_head = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage write.
  // NOTE: the array has no reset; entries are only visible once the pointers say they were written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column scan, press/release debounce, key-code queue.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 4,  // cycles per column window, 2..255
  parameter int unsigned DEBOUNCE   = 3,  // identical windows to accept press/release, 1..15
  parameter int unsigned FIFO_DEPTH = 4   // power of 2, >= 2
) (
  input  logic          clk,
  input  logic          rst,
  keypad_scan_if.slave  bus
);

  localparam logic [7:0] WIN_LAST = 8'(SCAN_DIV - 1);
  localparam logic [7:0] WIN_ONE  = 8'd1;
  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE - 1);
  localparam logic [3:0] CNT_ONE  = 4'd1;

  logic [3:0]  r_row_meta;
  logic [3:0]  r_row_s;
  logic [7:0]  r_win;
  kp_state_e   r_state;
  logic [3:0]  r_col;
  logic [1:0]  r_col_idx;
  logic [3:0]  r_cnt;
  logic [3:0]  r_cand_row;
  logic [3:0]  r_cand_code;
  logic        r_overflow;

  logic        w_win_end;
  kp_row_hit_t w_row;
  logic [3:0]  w_col_next;
  logic [1:0]  w_idx_next;
  logic        w_push;
  logic [3:0]  w_push_code;
  logic        w_full;
  logic        w_empty;
  logic [3:0]  w_head;

  assign w_win_end  = (r_win == WIN_LAST);
  assign w_row      = kp_decode_row(r_row_s);
  assign w_col_next = {r_col[2:0], r_col[3]};
  assign w_idx_next = r_col_idx + 2'd1;

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row_meta <= KP_ROW_IDLE;
      r_row_s    <= KP_ROW_IDLE;
    end else begin
      r_row_meta <= bus.row;
      r_row_s    <= r_row_meta;
    end
  end

  // Push strobe: fires on the window end that moves the FSM into HELD.
  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_push      = 1'b0;
    w_push_code = r_cand_code;
    if (w_win_end) begin
      case (r_state)
        KP_ST_SCAN: begin
          if (w_row.hit && (DEBOUNCE == 1)) begin
            w_push      = 1'b1;
            w_push_code = {w_row.idx, r_col_idx};
          end
        end
        KP_ST_DEB: begin
          if ((r_row_s == r_cand_row) && (r_cnt == DEB_LAST)) w_push = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Window timer and scan/debounce/held state machine.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win       <= '0;
      r_state     <= KP_ST_SCAN;
      r_col       <= KP_COL_INIT;
      r_col_idx   <= '0;
      r_cnt       <= '0;
      r_cand_row  <= KP_ROW_IDLE;
      r_cand_code <= '0;
    end else begin
      r_win <= w_win_end ? '0 : r_win + WIN_ONE;
      if (w_win_end) begin
        case (r_state)
          KP_ST_SCAN: begin
            if (w_row.hit) begin
              r_cand_row  <= r_row_s;
              r_cand_code <= {w_row.idx, r_col_idx};
              if (DEBOUNCE == 1) begin
                r_state <= KP_ST_HELD;
                r_cnt   <= '0;
              end else begin
                r_state <= KP_ST_DEB;
                r_cnt   <= CNT_ONE;
              end
            end else begin
              r_col     <= w_col_next;
              r_col_idx <= w_idx_next;
            end
          end
          KP_ST_DEB: begin
            if (r_row_s == r_cand_row) begin
              if (r_cnt == DEB_LAST) begin
                r_state <= KP_ST_HELD;
                r_cnt   <= '0;
              end else begin
                r_cnt <= r_cnt + CNT_ONE;
              end
            end else begin
              r_state   <= KP_ST_SCAN;
              r_cnt     <= '0;
              r_col     <= w_col_next;
              r_col_idx <= w_idx_next;
            end
          end
          KP_ST_HELD: begin
            // Column stays frozen until the key has been released long enough.
            if (r_row_s == KP_ROW_IDLE) begin
              if (r_cnt == DEB_LAST) begin
                r_state   <= KP_ST_SCAN;
                r_cnt     <= '0;
                r_col     <= w_col_next;
                r_col_idx <= w_idx_next;
              end else begin
                r_cnt <= r_cnt + CNT_ONE;
              end
            end else begin
              r_cnt <= '0;
            end
          end
          default: r_state <= KP_ST_SCAN;
        endcase
      end
    end
  end

  // Sticky overflow: set on a dropped push, cleared by any read; set wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_full && !bus.rd) begin
      r_overflow <= 1'b1;
    end else if (bus.rd) begin
      r_overflow <= 1'b0;
    end
  end

  keypad_scan_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (bus.rd),
    .i_data  (w_push_code),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign bus.col       = r_col;
  assign bus.key_val   = w_head;
  assign bus.key_valid = ~w_empty;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a physical keypad drives the rows, a
// window-level model predicts every output, and directed literals pin the model.
module tb_keypad_scan;

  localparam int SCAN_DIV   = 4;
  localparam int DEBOUNCE   = 3;
  localparam int FIFO_DEPTH = 4;

  localparam int M_SCAN = 0;
  localparam int M_CONF = 1;
  localparam int M_HELD = 2;

  logic clk;
  logic rst;
  keypad_scan_if kp ();

  keypad_scan #(
    .SCAN_DIV   (SCAN_DIV),
    .DEBOUNCE   (DEBOUNCE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Keypad stimulus: a pressed key code (-1 = none) or a raw row override.
  int         key_down = -1;
  bit         raw_mode = 1'b0;
  logic [3:0] raw_row  = 4'hF;

  // Model state.
  int         m_phase;
  int         m_col;
  int         m_mode;
  int         m_streak;
  logic [3:0] m_cand;
  int         m_code;
  logic [3:0] m_sync0;
  logic [3:0] m_sync1;
  int         m_q[$];
  bit         m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int low_row(input logic [3:0] r);
    int n;
    int idx;
    n = 0;
    idx = -1;
    for (int i = 0; i < 4; i++) begin
      if (!r[i]) begin
        n++;
        idx = i;
      end
    end
    return (n == 1) ? idx : -1;
  endfunction

  function automatic logic [3:0] exp_col();
    logic [3:0] v;
    v = 4'b0001 << m_col;
    return ~v;
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_col    = 0;
    m_mode   = M_SCAN;
    m_streak = 0;
    m_cand   = 4'hF;
    m_code   = 0;
    m_sync0  = 4'hF;
    m_sync1  = 4'hF;
    m_q.delete();
    m_ovf    = 1'b0;
  endtask

  // True when the coming clock edge accepts a key into the queue.
  function automatic bit model_will_push();
    if (m_phase != SCAN_DIV - 1) return 1'b0;
    if (m_mode == M_SCAN) return (DEBOUNCE == 1) && (low_row(m_sync1) >= 0);
    if (m_mode == M_CONF) return (m_sync1 == m_cand) && (m_streak + 1 == DEBOUNCE);
    return 1'b0;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit         push;
    bit         full;
    bit         rd_now;
    logic [3:0] row_now;
    int         r;
    if (!rst) begin
      model_reset();
      return;
    end
    rd_now  = kp.rd;
    row_now = kp.row;
    push    = model_will_push();
    if (m_phase == SCAN_DIV - 1) begin
      r = low_row(m_sync1);
      case (m_mode)
        M_SCAN: begin
          if (r >= 0) begin
            m_code = r * 4 + m_col;
            m_cand = m_sync1;
            if (DEBOUNCE == 1) begin
              m_mode = M_HELD;
              m_streak = 0;
            end else begin
              m_mode = M_CONF;
              m_streak = 1;
            end
          end else begin
            m_col = (m_col + 1) % 4;
          end
        end
        M_CONF: begin
          if (m_sync1 == m_cand) begin
            m_streak++;
            if (m_streak == DEBOUNCE) begin
              m_mode = M_HELD;
              m_streak = 0;
            end
          end else begin
            m_streak = 0;
            m_mode = M_SCAN;
            m_col = (m_col + 1) % 4;
          end
        end
        default: begin
          if (m_sync1 == 4'hF) begin
            m_streak++;
            if (m_streak == DEBOUNCE) begin
              m_mode = M_SCAN;
              m_streak = 0;
              m_col = (m_col + 1) % 4;
            end
          end else begin
            m_streak = 0;
          end
        end
      endcase
    end
    full = (m_q.size() == FIFO_DEPTH);
    if (push && full && !rd_now) m_ovf = 1'b1;
    else if (rd_now) m_ovf = 1'b0;
    if (rd_now && m_q.size() > 0) void'(m_q.pop_front());
    if (push && (!full || rd_now)) m_q.push_back(m_code);
    m_sync1 = m_sync0;
    m_sync0 = row_now;
    m_phase = (m_phase + 1) % SCAN_DIV;
  endtask

  // Physical keypad: a pressed key pulls its row low only while its column is driven.
  task automatic drive_row();
    int r;
    int c;
    if (raw_mode) begin
      kp.row = raw_row;
    end else if (key_down < 0) begin
      kp.row = 4'hF;
    end else begin
      r = key_down / 4;
      c = key_down % 4;
      kp.row = (kp.col[c] == 1'b0) ? ~(4'b0001 << r) : 4'hF;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    drive_row();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_rd();
    kp.rd = 1'b1;
    cycle();
    kp.rd = 1'b0;
  endtask

  task automatic press(input int code, input int hold_win, input int rel_win);
    key_down = code;
    drive_row();
    cycles(hold_win * SCAN_DIV);
    key_down = -1;
    drive_row();
    cycles(rel_win * SCAN_DIV);
  endtask

  task automatic lit(input string name, input logic [3:0] val, input logic valid, input logic ovf);
    check({name, "_key_val"},   32'(kp.key_val),   32'(val));
    check({name, "_key_valid"}, 32'(kp.key_valid), 32'(valid));
    check({name, "_overflow"},  32'(kp.overflow),  32'(ovf));
  endtask

  // Compare process: every output against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("col",       32'(kp.col),       32'(exp_col()));
      check("key_valid", 32'(kp.key_valid), 32'(m_q.size() > 0));
      check("key_val",   32'(kp.key_val),   (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
      check("overflow",  32'(kp.overflow),  32'(m_ovf));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int         exp_codes[4];
    bit         hit;
    rst    = 1'b0;
    kp.rd  = 1'b0;
    kp.row = 4'hF;
    model_reset();
    chk_en = 1'b1;
    @(negedge clk);
    cycle();
    rst = 1'b1;
    cycles(6);

    // Reset mid-scan: asynchronous, visible before any edge.
    check("pre_reset_col_moved", 32'(kp.col), 32'(4'b1101));
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_col", 32'(kp.col), 32'(4'b1110));
    lit("rst", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    cycles(2);
    rst = 1'b1;
    cycles(3);
    check("rst_col_3cyc", 32'(kp.col), 32'(4'b1110));
    cycle();
    check("rst_col_4cyc", 32'(kp.col), 32'(4'b1101));

    // Single press of key 9 (row 2, col 1), then pop.
    key_down = 9;
    drive_row();
    cycles(12 * SCAN_DIV);
    lit("press9", 4'd9, 1'b1, 1'b0);
    key_down = -1;
    drive_row();
    cycles(6 * SCAN_DIV);
    pulse_rd();
    lit("press9_rd", 4'd0, 1'b0, 1'b0);

    // Bounce: one window low, one window idle, one window low -> no push.
    raw_mode = 1'b1;
    raw_row = 4'b1011; drive_row(); cycles(SCAN_DIV);
    raw_row = 4'hF;    drive_row(); cycles(SCAN_DIV);
    raw_row = 4'b1011; drive_row(); cycles(SCAN_DIV);
    raw_row = 4'hF;    drive_row(); cycles(4 * SCAN_DIV);
    lit("bounce", 4'd0, 1'b0, 1'b0);

    // Two rows low: never a key.
    raw_row = 4'b1100; drive_row(); cycles(10 * SCAN_DIV);
    raw_row = 4'hF;    drive_row(); cycles(2 * SCAN_DIV);
    raw_mode = 1'b0;
    lit("two_rows", 4'd0, 1'b0, 1'b0);

    // Held key 0 for 20+ windows gives one entry; a re-press gives a second.
    press(0, 22, 5);
    press(0, 12, 6);
    lit("held_two", 4'd0, 1'b1, 1'b0);
    pulse_rd();
    lit("held_one_left", 4'd0, 1'b1, 1'b0);
    pulse_rd();
    lit("held_none_left", 4'd0, 1'b0, 1'b0);

    // Overflow: five presses into a four-entry queue.
    for (int k = 1; k <= 5; k++) press(k, 12, 6);
    lit("ovf_full", 4'd1, 1'b1, 1'b1);
    pulse_rd();
    lit("ovf_rd1", 4'd2, 1'b1, 1'b0);
    pulse_rd();
    lit("ovf_rd2", 4'd3, 1'b1, 1'b0);
    pulse_rd();
    lit("ovf_rd3", 4'd4, 1'b1, 1'b0);
    pulse_rd();
    lit("ovf_rd4", 4'd0, 1'b0, 1'b0);

    // Refill, then a push landing on the same cycle as a read while full.
    press(6, 12, 6);
    press(7, 12, 6);
    press(8, 12, 6);
    press(10, 12, 6);
    lit("refill", 4'd6, 1'b1, 1'b0);
    key_down = 11;
    drive_row();
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (model_will_push()) begin
        pulse_rd();
        hit = 1'b1;
        break;
      end
      cycle();
    end
    check("push_rd_window_reached", 32'(hit), 32'd1);
    lit("push_rd_full", 4'd7, 1'b1, 1'b0);
    key_down = -1;
    drive_row();
    cycles(6 * SCAN_DIV);
    exp_codes = '{7, 8, 10, 11};
    for (int i = 0; i < 4; i++) begin
      check("drain_val", 32'(kp.key_val), 32'(exp_codes[i]));
      pulse_rd();
    end
    lit("drained", 4'd0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
